ysyx_25030093_ifu: RTL and testbench

Instruction fetch unit for the multicycle core. Takes the next-PC pulse from the PC update stage and fetches the 32-bit instruction at that address over an AXI4-Lite-style read channel. Presents the instruction, its PC and an error code to the decode stage through a valid/ready handshake. After reset it starts the first fetch by itself, because the PC stage only pulses after write-back.

---
 rtl/ysyx_25030093_pkg.sv | 27 ++
 rtl/ysyx_25030093_ifu.sv | 141 ++++++++++++++
 tb/tb_ysyx_25030093_ifu.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_25030093_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_25030093_pkg
// Shared definitions for the instruction fetch unit of the multicycle core:
//   - ifu_state_e : fetch controller states (BOOT, IDLE, AR, R, HOLD)
//   - FE_*        : fetch_err codes handed to decode alongside the instruction
//   - NOP_INST    : addi x0, x0, 0, substituted whenever no real word is fetched
//   - RESP_OKAY   : the only read response treated as a successful fetch
// ---------------------------------------------------------------------------
package ysyx_25030093_pkg;

   typedef enum logic [2:0] {
      ST_BOOT,
      ST_IDLE,
      ST_AR,
      ST_R,
      ST_HOLD
   } ifu_state_e;

   localparam logic [1:0]  FE_NONE     = 2'b00;
   localparam logic [1:0]  FE_ACCESS   = 2'b01;
   localparam logic [1:0]  FE_MISALIGN = 2'b10;

   localparam logic [31:0] NOP_INST    = 32'h0000_0013;

   localparam logic [1:0]  RESP_OKAY   = 2'b00;

endpackage

// File: rtl/ysyx_25030093_ifu.sv
// ---------------------------------------------------------------------------
// ysyx_25030093_ifu
// Instruction fetch unit. Fetches one 32-bit word per PC pulse over an
// AXI4-Lite-style read channel and hands it to decode with valid/ready.
// Starts the very first fetch at RESET_PC on its own after reset.
//
// Ports:
//   clock, reset        core clock, asynchronous active-low reset
//   pc, in_valid_pc     next PC and its one-cycle strobe from the PC stage
//   araddr, arvalid,
//   arready             read address channel
//   rdata, rresp,
//   rvalid, rready      read data channel
//   inst, inst_pc,
//   fetch_err,
//   out_valid,
//   in_ready_idu        instruction handed to decode
//   busy                high whenever the unit is not waiting in IDLE
// ---------------------------------------------------------------------------
module ysyx_25030093_ifu
   import ysyx_25030093_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h2000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] pc,
   input  logic        in_valid_pc,
   output logic [31:0] araddr,
   output logic        arvalid,
   input  logic        arready,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rvalid,
   output logic        rready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic [1:0]  fetch_err,
   output logic        out_valid,
   input  logic        in_ready_idu,
   output logic        busy
);

   ifu_state_e  state;
   logic [31:0] addr_q;
   logic        accept_pc;
   logic        pc_aligned;

   // A new PC is only taken while idle, or in HOLD in the very cycle decode
   // takes the current instruction; pulses at any other time are dropped.
   assign accept_pc  = in_valid_pc &&
                       ((state == ST_IDLE) || ((state == ST_HOLD) && in_ready_idu));
   assign pc_aligned = (pc[1:0] == 2'b00);

   // The address register doubles as the bus address, so araddr cannot move
   // while a request is outstanding. rready is the only combinational output.
   assign araddr = addr_q;
   assign rready = (state == ST_R);

   // Fetch controller. Every registered output is updated together with the
   // state so that busy/arvalid/out_valid always describe the state being
   // entered. The HOLD branch first retires the current instruction and then
   // lets a same-cycle PC pulse override that, which is what removes the IDLE
   // bubble between back-to-back fetches.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= ST_BOOT;
         addr_q    <= RESET_PC;
         arvalid   <= 1'b0;
         out_valid <= 1'b0;
         inst      <= 32'h0;
         inst_pc   <= 32'h0;
         fetch_err <= FE_NONE;
         busy      <= 1'b1;
      end else begin
         case (state)
            ST_BOOT: begin
               state   <= ST_AR;
               addr_q  <= RESET_PC;
               arvalid <= 1'b1;
               busy    <= 1'b1;
            end

            ST_IDLE, ST_HOLD: begin
               if ((state == ST_HOLD) && in_ready_idu) begin
                  out_valid <= 1'b0;
                  state     <= ST_IDLE;
                  busy      <= 1'b0;
               end
               if (accept_pc) begin
                  busy <= 1'b1;
                  if (pc_aligned) begin
                     addr_q    <= pc;
                     arvalid   <= 1'b1;
                     out_valid <= 1'b0;
                     state     <= ST_AR;
                  end else begin
                     // Misaligned PCs never reach the bus; decode gets a NOP
                     // tagged with the fault instead.
                     inst      <= NOP_INST;
                     inst_pc   <= pc;
                     fetch_err <= FE_MISALIGN;
                     out_valid <= 1'b1;
                     state     <= ST_HOLD;
                  end
               end
            end

            ST_AR: begin
               if (arready) begin
                  arvalid <= 1'b0;
                  state   <= ST_R;
               end
            end

            ST_R: begin
               if (rvalid) begin
                  inst_pc   <= addr_q;
                  out_valid <= 1'b1;
                  state     <= ST_HOLD;
                  if (rresp == RESP_OKAY) begin
                     inst      <= rdata;
                     fetch_err <= FE_NONE;
                  end else begin
                     inst      <= NOP_INST;
                     fetch_err <= FE_ACCESS;
                  end
               end
            end

            default: begin
               state     <= ST_BOOT;
               arvalid   <= 1'b0;
               out_valid <= 1'b0;
               busy      <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_25030093_ifu.sv
// ---------------------------------------------------------------------------
// tb_ysyx_25030093_ifu
// Self-checking bench for the instruction fetch unit. Issued PCs push their
// expected instruction/PC/error into a scoreboard; a monitor pops and
// compares on each decode handshake. A small memory responder serves reads
// with configurable or random delays.
// ---------------------------------------------------------------------------
module tb_ysyx_25030093_ifu;

   localparam logic [31:0] RESET_PC = 32'h2000_0000;

   logic        clock;
   logic        reset;
   logic [31:0] pc;
   logic        in_valid_pc;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic [1:0]  fetch_err;
   logic        out_valid;
   logic        in_ready_idu;
   logic        busy;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [1:0]  err;
   } fetch_t;

   fetch_t      exp_q[$];
   logic [31:0] addr_exp_q[$];

   int errors = 0;
   int checks = 0;
   int force_aw = -1;
   int force_rw = -1;

   ysyx_25030093_ifu #(.RESET_PC(RESET_PC)) dut (
      .clock(clock),
      .reset(reset),
      .pc(pc),
      .in_valid_pc(in_valid_pc),
      .araddr(araddr),
      .arvalid(arvalid),
      .arready(arready),
      .rdata(rdata),
      .rresp(rresp),
      .rvalid(rvalid),
      .rready(rready),
      .inst(inst),
      .inst_pc(inst_pc),
      .fetch_err(fetch_err),
      .out_valid(out_valid),
      .in_ready_idu(in_ready_idu),
      .busy(busy)
   );

   // Free-running 10 ns clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   function automatic void checkOutput(input string name, input logic [31:0] act,
                                       input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got %h, required %h", name, act, req);
      end
   endfunction

   function automatic void timeoutFail(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s: timed out waiting, got none, required event", name);
   endfunction

   // Memory contents and fault map, shared by the responder and the model.
   function automatic logic is_fault(input logic [31:0] a);
      return a[7:4] == 4'hE;
   endfunction

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == RESET_PC) return 32'h0010_0093;
      return {a[15:0] ^ 16'hC0DE, a[15:0]};
   endfunction

   // What decode must eventually see for a given PC.
   function automatic fetch_t expect_fetch(input logic [31:0] a);
      fetch_t f;
      f.pc = a;
      if (a[1:0] != 2'b00) begin
         f.inst = 32'h0000_0013;
         f.err  = 2'b10;
      end else if (is_fault(a)) begin
         f.inst = 32'h0000_0013;
         f.err  = 2'b01;
      end else begin
         f.inst = mem_word(a);
         f.err  = 2'b00;
      end
      return f;
   endfunction

   function automatic int pick(input int forced, input int hi);
      return (forced >= 0) ? forced : int'($urandom_range(0, hi));
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Memory responder: offers arready after a chosen delay, then rvalid after
   // another delay. It also checks each requested address against the queue
   // of aligned PCs the bench has issued.
   int          mphase;
   int          await_n;
   int          rwait_n;
   logic        ar_seen;
   logic [31:0] maddr;

   task automatic drive_r();
      rvalid = 1'b1;
      rdata  = is_fault(maddr) ? 32'hDEAD_BEEF : mem_word(maddr);
      rresp  = is_fault(maddr) ? 2'b10 : 2'b00;
   endtask

   initial begin
      arready = 1'b0;
      rvalid  = 1'b0;
      rdata   = 32'h0;
      rresp   = 2'b00;
      mphase  = 0;
      await_n = 0;
      rwait_n = 0;
      ar_seen = 1'b0;
      maddr   = 32'h0;
      forever begin
         step();
         if (!reset) begin
            arready = 1'b0;
            rvalid  = 1'b0;
            mphase  = 0;
            ar_seen = 1'b0;
         end else if (mphase == 0) begin
            if (arready) begin
               arready = 1'b0;
               mphase  = 1;
               rwait_n = pick(force_rw, 3);
               if (rwait_n == 0) drive_r();
            end else if (arvalid) begin
               if (!ar_seen) begin
                  ar_seen = 1'b1;
                  maddr   = araddr;
                  await_n = pick(force_aw, 3);
                  if (addr_exp_q.size() == 0) begin
                     checks++;
                     errors++;
                     $display("[TB] FAIL unexpected_ar: got araddr %h, required no request", araddr);
                  end else begin
                     checkOutput("araddr", araddr, addr_exp_q.pop_front());
                  end
               end
               if (await_n == 0) arready = 1'b1;
               else await_n--;
            end
         end else begin
            if (rvalid) begin
               rvalid  = 1'b0;
               mphase  = 0;
               ar_seen = 1'b0;
            end else if (rwait_n == 0) begin
               drive_r();
            end else begin
               rwait_n--;
            end
         end
      end
   end

   // Monitor on the falling edge: scoreboard pops on decode handshakes, plus
   // hold-stability of both handshakes and the one-cycle R-to-output rule.
   logic        p_ov, p_rdy, p_av, p_ar, p_rhs;
   logic [31:0] p_inst, p_pc, p_addr, p_maddr;
   logic [1:0]  p_err;

   initial begin
      fetch_t f;
      p_ov = 1'b0; p_rdy = 1'b0; p_av = 1'b0; p_ar = 1'b0; p_rhs = 1'b0;
      p_inst = 32'h0; p_pc = 32'h0; p_addr = 32'h0; p_maddr = 32'h0; p_err = 2'b00;
      forever begin
         @(negedge clock);
         if (!reset) begin
            p_ov  = 1'b0;
            p_av  = 1'b0;
            p_rhs = 1'b0;
         end else begin
            if (p_ov && !p_rdy) begin
               checkOutput("hold_out_valid", {31'h0, out_valid}, 32'h1);
               checkOutput("hold_inst", inst, p_inst);
               checkOutput("hold_inst_pc", inst_pc, p_pc);
               checkOutput("hold_fetch_err", {30'h0, fetch_err}, {30'h0, p_err});
            end
            if (p_av && !p_ar) begin
               checkOutput("ar_hold_arvalid", {31'h0, arvalid}, 32'h1);
               checkOutput("ar_hold_araddr", araddr, p_addr);
            end
            if (p_rhs) begin
               checkOutput("r_to_out_valid", {31'h0, out_valid}, 32'h1);
               checkOutput("r_to_out_pc", inst_pc, p_maddr);
            end
            if (out_valid && in_ready_idu) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL unexpected_output: got inst %h pc %h, required nothing", inst, inst_pc);
               end else begin
                  f = exp_q.pop_front();
                  checkOutput("sb_inst", inst, f.inst);
                  checkOutput("sb_inst_pc", inst_pc, f.pc);
                  checkOutput("sb_fetch_err", {30'h0, fetch_err}, {30'h0, f.err});
               end
            end
            if (in_valid_pc && !(!busy || (out_valid && in_ready_idu))) begin
               errors++;
               $display("[TB] FAIL pc_protocol: got in_valid_pc while busy, required none");
            end
            p_ov    = out_valid;
            p_rdy   = in_ready_idu;
            p_inst  = inst;
            p_pc    = inst_pc;
            p_err   = fetch_err;
            p_av    = arvalid;
            p_ar    = arready;
            p_addr  = araddr;
            p_rhs   = rvalid && rready;
            p_maddr = maddr;
         end
      end
   end

   task automatic wait_idle();
      in_ready_idu = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if (!busy && exp_q.size() == 0) return;
         step();
      end
      timeoutFail("wait_idle");
   endtask

   // Pulses one PC as soon as the unit can legally take it.
   task automatic issue_pc(input logic [31:0] a);
      for (int i = 0; i < 200; i++) begin
         if (!busy || (out_valid && in_ready_idu)) begin
            pc          = a;
            in_valid_pc = 1'b1;
            exp_q.push_back(expect_fetch(a));
            if (a[1:0] == 2'b00) addr_exp_q.push_back(a);
            step();
            in_valid_pc = 1'b0;
            return;
         end
         step();
      end
      timeoutFail("issue_pc");
   endtask

   // Random traffic: random decode backpressure, bus delays and PCs (about a
   // quarter misaligned, some landing in the faulting region).
   task automatic applyStimulus(input int n_issue);
      int          issued;
      logic [31:0] a;
      issued   = 0;
      force_aw = -1;
      force_rw = -1;
      for (int cyc = 0; cyc < 4000 && issued < n_issue; cyc++) begin
         in_ready_idu = ($urandom_range(0, 3) != 0);
         if ((!busy || (out_valid && in_ready_idu)) && $urandom_range(0, 1) == 1) begin
            a = RESET_PC + 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            pc          = a;
            in_valid_pc = 1'b1;
            exp_q.push_back(expect_fetch(a));
            if (a[1:0] == 2'b00) addr_exp_q.push_back(a);
            issued++;
         end else begin
            in_valid_pc = 1'b0;
         end
         step();
      end
      in_valid_pc = 1'b0;
      if (issued < n_issue) timeoutFail("random_issue");
   endtask

   task automatic wait_out_valid(input string name);
      for (int i = 0; i < 50; i++) begin
         if (out_valid) return;
         step();
      end
      timeoutFail(name);
   endtask

   initial begin
      reset        = 1'b0;
      pc           = 32'h0;
      in_valid_pc  = 1'b0;
      in_ready_idu = 1'b0;
      force_aw     = 0;
      force_rw     = 0;

      // Reset values.
      repeat (3) step();
      checkOutput("rst_arvalid", {31'h0, arvalid}, 32'h0);
      checkOutput("rst_rready", {31'h0, rready}, 32'h0);
      checkOutput("rst_out_valid", {31'h0, out_valid}, 32'h0);
      checkOutput("rst_araddr", araddr, RESET_PC);
      checkOutput("rst_inst", inst, 32'h0);
      checkOutput("rst_inst_pc", inst_pc, 32'h0);
      checkOutput("rst_fetch_err", {30'h0, fetch_err}, 32'h0);
      checkOutput("rst_busy", {31'h0, busy}, 32'h1);

      // Self-started boot fetch.
      exp_q.push_back(expect_fetch(RESET_PC));
      addr_exp_q.push_back(RESET_PC);
      reset = 1'b1;
      step();
      checkOutput("boot_arvalid", {31'h0, arvalid}, 32'h1);
      checkOutput("boot_araddr", araddr, RESET_PC);
      wait_idle();

      // Minimum latency with the bus answering immediately.
      issue_pc(32'h2000_0020);
      checkOutput("lat_arvalid", {31'h0, arvalid}, 32'h1);
      checkOutput("lat_no_out_c1", {31'h0, out_valid}, 32'h0);
      step();
      checkOutput("lat_rready", {31'h0, rready}, 32'h1);
      step();
      checkOutput("lat_out_valid", {31'h0, out_valid}, 32'h1);
      wait_idle();

      // Stalled bus, then decode backpressure and a back-to-back PC.
      force_aw     = 3;
      force_rw     = 2;
      in_ready_idu = 1'b0;
      issue_pc(32'h2000_0010);
      wait_out_valid("stall_out_valid");
      repeat (4) step();
      force_aw     = 0;
      force_rw     = 0;
      in_ready_idu = 1'b1;
      issue_pc(32'h2000_0014);
      checkOutput("b2b_arvalid", {31'h0, arvalid}, 32'h1);
      checkOutput("b2b_araddr", araddr, 32'h2000_0014);
      wait_idle();

      // Misaligned PC: no bus access, result one cycle later.
      issue_pc(32'h2000_0002);
      checkOutput("mis_out_valid", {31'h0, out_valid}, 32'h1);
      checkOutput("mis_no_arvalid", {31'h0, arvalid}, 32'h0);
      wait_idle();

      // Access fault on the bus.
      issue_pc(32'h2000_00E4);
      wait_idle();

      // Random traffic.
      applyStimulus(60);
      wait_idle();

      // Reset while the read data phase is in progress.
      force_aw = 0;
      force_rw = 3;
      issue_pc(32'h2000_0040);
      for (int i = 0; i < 50 && !rready; i++) step();
      if (!rready) timeoutFail("wait_rready");
      #2;
      reset = 1'b0;
      #1;
      checkOutput("rstR_rready", {31'h0, rready}, 32'h0);
      checkOutput("rstR_arvalid", {31'h0, arvalid}, 32'h0);
      checkOutput("rstR_out_valid", {31'h0, out_valid}, 32'h0);
      exp_q.delete();
      addr_exp_q.delete();
      repeat (2) step();
      force_rw = 0;
      exp_q.push_back(expect_fetch(RESET_PC));
      addr_exp_q.push_back(RESET_PC);
      reset = 1'b1;
      step();
      checkOutput("reboot_arvalid", {31'h0, arvalid}, 32'h1);
      checkOutput("reboot_araddr", araddr, RESET_PC);
      wait_idle();

      checkOutput("left_expected", exp_q.size(), 32'h0);
      checkOutput("left_addresses", addr_exp_q.size(), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Absolute time limit so the run can never hang.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got no completion, required finish before time limit");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "[TB] time limit reached");
   end

endmodule
